// File: rtl/tick_generator_pkg.sv
// Configuration constants for the tick generator.
//
// Holds the channel count, counter and fraction widths, and the reset
// divisors and fractions for the RTC and UART baud channels. The values are
// derived from the core clock frequency and the target rates.
//
// Contents:
//   tick_channels, tick_cnt_width, tick_frac_width - generator geometry
//   clk_divider_rtc, rtc_frac_init                 - RTC channel (ch0) defaults
//   clks_per_bit, baud_frac_init                   - UART bit channel (ch1) defaults
//   tick_cfg_type                                  - per-channel configuration record

package tick_generator_pkg;

  localparam int unsigned tick_channels   = 2;
  localparam int unsigned tick_cnt_width  = 16;
  localparam int unsigned tick_frac_width = 8;

  localparam longint unsigned clk_freq  = 64'd20_000_000;
  localparam longint unsigned rtc_rate  = 64'd32_768;
  localparam longint unsigned baud_rate = 64'd115_200;

  // The counter runs DIV+1 cycles per period, so the integer part of the
  // ratio is stored minus one.
  function automatic int unsigned ratio_div(input longint unsigned clk,
                                            input longint unsigned rate);
    return 32'((clk / rate) - 64'd1);
  endfunction

  // Fractional part of the ratio, scaled to the accumulator width.
  function automatic int unsigned ratio_frac(input longint unsigned clk,
                                             input longint unsigned rate);
    return 32'(((clk << tick_frac_width) / rate) % (64'd1 << tick_frac_width));
  endfunction

  localparam int unsigned clk_divider_rtc = ratio_div(clk_freq, rtc_rate);
  localparam int unsigned clks_per_bit    = ratio_div(clk_freq, baud_rate);
  localparam int unsigned rtc_frac_init   = ratio_frac(clk_freq, rtc_rate);
  localparam int unsigned baud_frac_init  = ratio_frac(clk_freq, baud_rate);

  typedef struct packed {
    logic [tick_cnt_width-1:0]  div;
    logic [tick_frac_width-1:0] frac;
    logic                       en;
  } tick_cfg_type;

endpackage

// File: rtl/tick_generator_channel.sv
// One tick channel: down-counter, fractional accumulator and shadow config.
//
// Ports:
//   clock         - core clock, all state on rising edge
//   reset         - asynchronous, active-low reset
//   cfg_we        - write strobe for this channel's div/frac/en
//   cfg_div       - new divisor
//   cfg_frac      - new fraction
//   cfg_en        - new enable
//   restart       - reload counter with DIV, clear accumulator
//   restart_half  - reload counter with DIV>>1, clear accumulator
//   tick          - registered one-cycle pulse per period

module tick_generator_channel
  import tick_generator_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH  = tick_cnt_width,
  parameter int unsigned           FRAC_WIDTH = tick_frac_width,
  parameter logic [CNT_WIDTH-1:0]  DIV_INIT   = '0,
  parameter logic [FRAC_WIDTH-1:0] FRAC_INIT  = '0,
  parameter logic                  EN_INIT    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  input  logic                  cfg_en,
  input  logic                  restart,
  input  logic                  restart_half,
  output logic                  tick
);

  logic [CNT_WIDTH-1:0]  div_q;
  logic [FRAC_WIDTH-1:0] frac_q;
  logic                  en_q;
  logic [CNT_WIDTH:0]    cnt_q;
  logic [FRAC_WIDTH-1:0] acc_q;
  logic                  tick_q;

  logic [CNT_WIDTH-1:0]  div_eff;
  logic [FRAC_WIDTH-1:0] frac_eff;
  logic                  fire;
  logic                  enable_rise;
  logic                  carry;
  logic [FRAC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH:0]    load_full;
  logic [CNT_WIDTH:0]    load_half;

  // A write landing in the same cycle as a reload or restart is bypassed so
  // the load already uses the new divisor and fraction.
  always_comb begin
    div_eff          = cfg_we ? cfg_div : div_q;
    frac_eff         = cfg_we ? cfg_frac : frac_q;
    fire             = en_q && (cnt_q == '0);
    enable_rise      = cfg_we && cfg_en && !en_q;
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_eff};
    load_full        = {1'b0, div_eff};
    load_half        = {2'b00, div_eff[CNT_WIDTH-1:1]};
  end

  // Load priority: half restart, then full restart (or re-enable), then the
  // periodic reload on a tick, then plain counting. A tick due in a restart
  // cycle is still emitted; only the counter load is overridden.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= DIV_INIT;
      frac_q <= FRAC_INIT;
      en_q   <= EN_INIT;
      cnt_q  <= {1'b0, DIV_INIT};
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= fire;
      if (cfg_we) begin
        div_q  <= cfg_div;
        frac_q <= cfg_frac;
        en_q   <= cfg_en;
      end
      if (restart_half) begin
        cnt_q <= load_half;
        acc_q <= '0;
      end else if (restart || enable_rise) begin
        cnt_q <= load_full;
        acc_q <= '0;
      end else if (fire) begin
        cnt_q <= carry ? (load_full + 1'b1) : load_full;
        acc_q <= acc_sum;
      end else if (en_q) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel fractional clock-enable generator.
//
// Each channel emits a one-cycle tick every DIV+1 or DIV+2 cycles so that the
// average period is DIV+1+FRAC/2^FRAC_WIDTH. Channel 0 drives the RTC/mtime
// increment, channel 1 the UART bit timing.
//
// Ports:
//   reset         - asynchronous, active-low reset
//   clock         - core clock
//   cfg_we        - configuration write strobe
//   cfg_chan      - channel index for the write (unknown index: ignored)
//   cfg_div       - new divisor
//   cfg_frac      - new fraction
//   cfg_en        - new enable
//   restart       - per channel: reload with DIV, clear accumulator
//   restart_half  - per channel: reload with DIV>>1 (UART mid-bit)
//   tick          - per channel one-cycle pulse

module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int unsigned                           CHANNELS   = tick_channels,
  parameter int unsigned                           CNT_WIDTH  = tick_cnt_width,
  parameter int unsigned                           FRAC_WIDTH = tick_frac_width,
  parameter logic [CHANNELS-1:0][CNT_WIDTH-1:0]    DIV_INIT   =
    {CNT_WIDTH'(clks_per_bit), CNT_WIDTH'(clk_divider_rtc)},
  parameter logic [CHANNELS-1:0][FRAC_WIDTH-1:0]   FRAC_INIT  =
    {FRAC_WIDTH'(baud_frac_init), FRAC_WIDTH'(rtc_frac_init)},
  parameter logic [CHANNELS-1:0]                   EN_INIT    = '1,
  localparam int unsigned CHAN_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  reset,
  input  logic                  clock,
  input  logic                  cfg_we,
  input  logic [CHAN_WIDTH-1:0] cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  input  logic                  cfg_en,
  input  logic [CHANNELS-1:0]   restart,
  input  logic [CHANNELS-1:0]   restart_half,
  output logic [CHANNELS-1:0]   tick
);

  logic [CHANNELS-1:0] chan_we;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // An index matching no channel produces no strobe, so the write is lost.
    assign chan_we[c] = cfg_we && (cfg_chan == CHAN_WIDTH'(c));

    tick_generator_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH),
      .DIV_INIT  (DIV_INIT[c]),
      .FRAC_INIT (FRAC_INIT[c]),
      .EN_INIT   (EN_INIT[c])
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .cfg_we      (chan_we[c]),
      .cfg_div     (cfg_div),
      .cfg_frac    (cfg_frac),
      .cfg_en      (cfg_en),
      .restart     (restart[c]),
      .restart_half(restart_half[c]),
      .tick        (tick[c])
    );
  end

endmodule
